// File: rtl/flags_unit.sv
// Execute-stage condition-flag producer: combinational NZCV from the ALU operands plus the
// architectural {N,Z,C,V} register, with a multi-cycle flag-setting multiply path.
module flags_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [1:0]       FlagsWrite,
  input  logic             CondEx,
  input  logic             MulStart,
  input  logic [WIDTH-1:0] MulResult,
  output logic [3:0]       ALUFlags,
  output logic [3:0]       Flags,
  output logic             FlagsValid,
  output logic             FlagsStall
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;
  logic             en;

  // SUB is A + ~B + 1, so a single adder covers both and V uses the effective B sign.
  always_comb begin
    sub   = (ALUControl == 2'b01);
    b_eff = sub ? ~SrcB : SrcB;
    wide  = {1'b0, SrcA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    res   = wide[WIDTH-1:0];
    carry = 1'b0;
    ovf   = 1'b0;
    case (ALUControl)
      2'b00, 2'b01: begin
        carry = wide[WIDTH];
        ovf   = (SrcA[WIDTH-1] == b_eff[WIDTH-1]) & (res[WIDTH-1] != SrcA[WIDTH-1]);
      end
      2'b10:   res = SrcA & SrcB;
      default: res = SrcA | SrcB;
    endcase
    ALUFlags = {res[WIDTH-1], (res == '0), carry, ovf};
  end

  assign en         = ~stall & ~flush & CondEx & (state == IDLE);
  assign FlagsStall = ~FlagsValid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      Flags      <= '0;
      FlagsValid <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            if (MulStart) begin
              state      <= BUSY;
              cnt        <= 4'(MUL_LAT - 1);
              FlagsValid <= 1'b0;
            end else begin
              if (FlagsWrite[1]) Flags[3:2] <= ALUFlags[3:2];
              if (FlagsWrite[0]) Flags[1:0] <= ALUFlags[1:0];
            end
          end
        end
        BUSY: begin
          // Multiply is older than anything in flight, so stall/flush cannot hold it.
          if (cnt == '0) begin
            Flags[3:2] <= {MulResult[WIDTH-1], (MulResult == '0)};
            state      <= IDLE;
            FlagsValid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flags_unit.sv
// Bench for flags_unit: vector table, directed multi-cycle sequences, and randomized traffic
// checked against an arithmetic reference model.
module tb_flags_unit;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 3;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic              clk = 1'b0;
  logic              reset, stall, flush, CondEx, MulStart;
  logic [1:0]        ALUControl, FlagsWrite;
  logic [WIDTH-1:0]  SrcA, SrcB, MulResult;
  logic [3:0]        ALUFlags, Flags;
  logic              FlagsValid, FlagsStall;

  int pass_cnt = 0;
  int total    = 0;

  logic [3:0] mflags;
  int         pend;

  typedef struct {
    logic [1:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  exp;
  } vec_t;
  vec_t vecs [8];

  flags_unit #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
    .FlagsWrite(FlagsWrite), .CondEx(CondEx), .MulStart(MulStart),
    .MulResult(MulResult), .ALUFlags(ALUFlags), .Flags(Flags),
    .FlagsValid(FlagsValid), .FlagsStall(FlagsStall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference ALU flags from integer arithmetic on the operand values.
  function automatic logic [3:0] ref_alu(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, sr;
    logic [32:0] u;
    logic [31:0] s;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'b00: begin
        u = {1'b0, a} + {1'b0, b};
        s = u[31:0];
        c = (u > 33'h0FFFFFFFF);
        sr = sa + sb;
        v = (sr > SMAX) || (sr < SMIN);
      end
      2'b01: begin
        s = a - b;
        c = (a >= b);
        sr = sa - sb;
        v = (sr > SMAX) || (sr < SMIN);
      end
      2'b10:   s = a & b;
      default: s = a | b;
    endcase
    return {s[31], (s == 32'd0), c, v};
  endfunction

  // One clock: model follows the inputs seen at the edge, then registered outputs are compared.
  task automatic tick(input string tag);
    @(posedge clk);
    if (reset) begin
      mflags = 4'b0000;
      pend   = 0;
    end else if (pend > 0) begin
      if (pend == 1) mflags[3:2] = {MulResult[31], (MulResult == 32'd0)};
      pend--;
    end else if (!stall && !flush && CondEx) begin
      if (MulStart) pend = MUL_LAT;
      else begin
        if (FlagsWrite[1]) mflags[3:2] = ref_alu(ALUControl, SrcA, SrcB) >> 2;
        if (FlagsWrite[0]) mflags[1:0] = ref_alu(ALUControl, SrcA, SrcB) & 4'b0011;
      end
    end
    #1;
    chk({tag, ".flags"}, {28'd0, Flags}, {28'd0, mflags});
    chk({tag, ".valid"}, {31'd0, FlagsValid}, {31'd0, pend == 0});
    chk({tag, ".stall"}, {31'd0, FlagsStall}, {31'd0, pend != 0});
  endtask

  task automatic idle_in();
    reset = 0; stall = 0; flush = 0; CondEx = 0; MulStart = 0;
    FlagsWrite = 2'b00; ALUControl = 2'b00; SrcA = 0; SrcB = 0; MulResult = 32'hDEAD_BEEF;
  endtask

  task automatic alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] fw, input logic ce);
    ALUControl = op; SrcA = a; SrcB = b; FlagsWrite = fw; CondEx = ce;
  endtask

  initial begin
    vecs[0] = '{2'b00, 32'h7FFFFFFF, 32'h00000001, 4'b1001};
    vecs[1] = '{2'b00, 32'hFFFFFFFF, 32'h00000001, 4'b0110};
    vecs[2] = '{2'b01, 32'h00000005, 32'h00000005, 4'b0110};
    vecs[3] = '{2'b01, 32'h00000000, 32'h00000001, 4'b1000};
    vecs[4] = '{2'b01, 32'h80000000, 32'h00000001, 4'b0011};
    vecs[5] = '{2'b10, 32'hF0F0F0F0, 32'h0F0F0F0F, 4'b0100};
    vecs[6] = '{2'b11, 32'h80000000, 32'h00000001, 4'b1000};
    vecs[7] = '{2'b00, 32'h80000000, 32'h80000000, 4'b0111};
    mflags = 4'b0000;
    pend   = 0;

    // Reset
    idle_in();
    reset = 1;
    tick("rst");
    chk("rst.flags0", {28'd0, Flags}, 32'h0);
    chk("rst.valid1", {31'd0, FlagsValid}, 32'h1);
    chk("rst.stall0", {31'd0, FlagsStall}, 32'h0);
    reset = 0;

    // Vector table: combinational flags, then committed value one cycle later
    foreach (vecs[i]) begin
      alu(vecs[i].ctrl, vecs[i].a, vecs[i].b, 2'b11, 1'b1);
      #1;
      chk($sformatf("vec%0d.alu", i), {28'd0, ALUFlags}, {28'd0, vecs[i].exp});
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.commit", i), {28'd0, Flags}, {28'd0, vecs[i].exp});
    end

    // Partial writes: C,V only then N,Z only
    reset = 1; tick("rst2"); reset = 0;
    alu(2'b00, 32'h7FFFFFFF, 32'h1, 2'b01, 1'b1);
    tick("cv");
    chk("cv.only", {28'd0, Flags}, 32'h1);
    alu(2'b01, 32'd5, 32'd5, 2'b10, 1'b1);
    tick("nz");
    chk("nz.only", {28'd0, Flags}, 32'h5);

    // Blocked commits: CondEx=0, stall, flush
    alu(2'b00, 32'hFFFFFFFF, 32'h1, 2'b11, 1'b0);
    tick("ce0");
    CondEx = 1; stall = 1;
    tick("stl");
    stall = 0; flush = 1;
    tick("fls");
    chk("hold", {28'd0, Flags}, 32'h5);
    flush = 0;

    // Multiply: valid low exactly MUL_LAT cycles, ALU write on the start cycle ignored
    alu(2'b00, 32'hFFFFFFFF, 32'h2, 2'b11, 1'b1);
    tick("pre");
    chk("pre.flags", {28'd0, Flags}, 32'h2);
    alu(2'b00, 32'h7FFFFFFF, 32'h1, 2'b11, 1'b1);
    MulStart = 1;
    tick("ms");
    chk("ms.v0", {31'd0, FlagsValid}, 32'h0);
    chk("ms.flags", {28'd0, Flags}, 32'h2);
    MulStart = 0; stall = 1; MulResult = 32'h80000000;
    tick("b1");
    chk("b1.v0", {31'd0, FlagsValid}, 32'h0);
    stall = 0;
    tick("b2");
    chk("b2.v0", {31'd0, FlagsStall}, 32'h1);
    stall = 1; MulResult = 32'd0;
    tick("b3");
    chk("mul.done", {28'd0, Flags}, 32'h6);
    chk("mul.v1", {31'd0, FlagsValid}, 32'h1);
    stall = 0;

    // Reset mid-multiply abandons it
    idle_in();
    CondEx = 1; MulStart = 1;
    tick("ms2");
    idle_in();
    MulResult = 32'h80000001;
    tick("r.b1");
    reset = 1;
    tick("r.b2");
    chk("rbusy.flags", {28'd0, Flags}, 32'h0);
    chk("rbusy.v1", {31'd0, FlagsValid}, 32'h1);
    reset = 0;
    repeat (3) tick("r.after");
    chk("rbusy.ignored", {28'd0, Flags}, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 63) == 0);
      stall      = ($urandom_range(0, 5) == 0);
      flush      = ($urandom_range(0, 7) == 0);
      CondEx     = ($urandom_range(0, 4) != 0);
      MulStart   = ($urandom_range(0, 7) == 0);
      FlagsWrite = 2'($urandom);
      ALUControl = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       begin SrcA = $urandom; SrcB = SrcA; end
        1:       begin SrcA = 32'h80000000 ^ 32'($urandom_range(0, 3)); SrcB = $urandom_range(0, 3); end
        default: begin SrcA = $urandom; SrcB = $urandom; end
      endcase
      MulResult = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      #1;
      chk("rnd.alu", {28'd0, ALUFlags}, {28'd0, ref_alu(ALUControl, SrcA, SrcB)});
      tick("rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
